pll_rst_seq: RTL
================

# pll_rst_seq

PLL supervisor and multi-domain reset sequencer. It sits beside the clock generator in the `clk24_ref` domain and replaces the fixed power-on PLL reset pulse with a parametrised sequence:
- PLL reset pulse, then a lock wait with timeout and bounded retries.
- Lock-stability qualification, then staggered release of N per-domain resets.
- On lock loss, all domain resets are re-asserted and the whole sequence restarts.

Each `dom_rst[i]` is re-synchronised inside its destination clock domain; this block does not do that.

## Interface
- `PLL_RST_CYCLES`, 4: `pll_rst` pulse length in cycles, ≥1.
- `LOCK_TIMEOUT`, 24000: cycles to wait for lock before retrying (1 ms at 24 MHz), ≥2.
- `STABLE_CYCLES`, 256: consecutive synchronised-lock cycles required before release, ≥1.
- `N_DOMAINS`, 5: number of domain resets, ≥1.
- `RELEASE_GAP`, 16: cycles between successive domain releases, ≥1.
- `MAX_RETRIES`, 7: consecutive failed lock attempts before FAULT, 1..255.
- `clk24_ref` in 1: reference clock, the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `locked` in 1: PLL lock, asynchronous to `clk24_ref`.
- `pll_rst` out 1: PLL reset, active-high.
- `dom_rst` out N_DOMAINS: per-domain reset, active-high.
- `ready` out 1: all domains released, lock good.
- `lock_lost` out 1: one-cycle pulse on loss of lock in RELEASE or RUN.
- `fault` out 1: retry budget exhausted; sticky.
- `retries` out 8: count of consecutive failed attempts.

## Operation
- `locked` passes through a 2-flop synchroniser to give `locked_s` (2-cycle latency).
- All outputs are registered and decoded from next-state, so each output changes in the same cycle as the state register.
- While `rst` is high, and immediately on its assertion:
  - state RESET_PLL, counter 0, `retries` 0.
  - `pll_rst`=1, `dom_rst`=all 1.
  - `ready`=0, `lock_lost`=0, `fault`=0.
- **RESET_PLL**: `pll_rst`=1 for exactly PLL_RST_CYCLES cycles, then WAIT_LOCK with counter cleared. `pll_rst`=0 from WAIT_LOCK onward.
- **WAIT_LOCK**: counter increments each cycle.
  - `locked_s`=1: go to STABLE, counter cleared.
  - Counter reaches LOCK_TIMEOUT-1 with `locked_s`=0: this is a failed attempt (see below).
- **STABLE**: counter increments while `locked_s`=1.
  - After STABLE_CYCLES consecutive high cycles: go to RELEASE.
  - `locked_s`=0 at any point: failed attempt.
- **Failed attempt**: `retries`+1. If the new value equals MAX_RETRIES, go to FAULT; otherwise go to RESET_PLL.
- **RELEASE**: index k starts at 0. `dom_rst[k]` goes low; after RELEASE_GAP cycles k+1 goes low, and so on. Domains release in index order; a released bit stays low. The cycle after `dom_rst[N_DOMAINS-1]` goes low, go to RUN.
- **RUN**: `ready`=1, `retries` cleared to 0.
- **Lock loss** (`locked_s`=0 in RELEASE or RUN):
  - Same transition cycle: `dom_rst`=all 1, `ready`=0, `lock_lost`=1 for one cycle, go to RESET_PLL.
  - `retries` is not incremented.
- **FAULT**: `pll_rst`=1, `dom_rst`=all 1, `fault`=1, `ready`=0. Exit only via `rst`.
- Counter width is `$clog2` of the largest of LOCK_TIMEOUT, STABLE_CYCLES and RELEASE_GAP, plus 1. The counter never wraps: every state clears it on exit.

## Timing
- Reset release to `pll_rst` falling: PLL_RST_CYCLES cycles.
- `locked` pin rising to RELEASE entry (first `dom_rst` falling): 2 (sync) + STABLE_CYCLES + 1 cycles.
- `dom_rst[i]` falls at E + i·RELEASE_GAP, where E is the RELEASE entry cycle.
- `ready` rises at E + (N_DOMAINS-1)·RELEASE_GAP + 1.
- `locked` pin falling to `dom_rst` all high: 3 cycles (2 sync + 1 registered).
- `locked_s` falling in the same cycle as the STABLE→RELEASE transition takes priority: go to RESET_PLL, counted as a failed attempt.
- `rst` mid-sequence: outputs take their reset values asynchronously, with no glitch on `dom_rst`. Sequencing restarts on the first clock edge after `rst` deasserts.

## Structure
- Shared package `clkgen_pkg`: state encoding localparams (RESET_PLL, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT) and a counter-width helper function.
- One sub-module: `sync2`, a 2-flop synchroniser with asynchronous active-high reset to 0. It is reused for `dom_rst` re-sync in the destination domains.

## Test plan
Parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, N_DOMAINS=3, RELEASE_GAP=4, MAX_RETRIES=2.

- **Nominal**: `locked` rises 20 cycles after `rst` release.
  - `pll_rst` is high for cycles 0–3.
  - `dom_rst` goes 3'b111→110→100→000 at E, E+4, E+8, with E = lock+11.
  - `ready` rises at E+9; `retries`=0.
- **Timeout/retry**: `locked` held low.
  - Two 4-cycle `pll_rst` pulses, 100 cycles of WAIT_LOCK each.
  - After the second timeout, `fault`=1 and `pll_rst` stays high.
  - `dom_rst`=111 throughout.
- **Unstable lock**: `locked` high 5 cycles then low.
  - `retries`=1, a new `pll_rst` pulse, no `dom_rst` change.
  - Second lock held: normal release; `retries` returns to 0 on RUN entry.
- **Lock loss in RUN**: drop `locked` once in RUN.
  - 3 cycles later: `dom_rst`=111, `ready`=0, a one-cycle `lock_lost` pulse.
  - `pll_rst` pulse follows; `retries` unchanged.
- **Lock loss mid-RELEASE**: drop `locked` at E+5 (`dom_rst`=100).
  - All bits back to 1 within 3 cycles; `lock_lost` pulse.
- **Async reset**: assert `rst` mid-edge in RUN and in FAULT.
  - Outputs reach reset values before the next clock edge; `fault` clears.

Source files
------------

// File: rtl/clkgen_pkg.sv
// Shared definitions for the clock generator slice: sequencer state encoding
// and the counter-width helper.
package clkgen_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_t;

  // One spare bit above the largest terminal count so the compare never aliases.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser, asynchronous active-high reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL supervisor and staggered multi-domain reset sequencer in the clk24_ref domain.
// Outputs are registered from next-state so they move together with the state register.
module pll_rst_seq
  import clkgen_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 4,
  parameter int LOCK_TIMEOUT   = 24000,
  parameter int STABLE_CYCLES  = 256,
  parameter int N_DOMAINS      = 5,
  parameter int RELEASE_GAP    = 16,
  parameter int MAX_RETRIES    = 7
) (
  input  logic                 clk24_ref,
  input  logic                 rst,
  input  logic                 locked,
  output logic                 pll_rst,
  output logic [N_DOMAINS-1:0] dom_rst,
  output logic                 ready,
  output logic                 lock_lost,
  output logic                 fault,
  output logic [7:0]           retries
);

  localparam int CW = cnt_width(LOCK_TIMEOUT, STABLE_CYCLES, RELEASE_GAP);
  localparam int KW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [KW-1:0]        k, k_n;
  logic [7:0]           retries_n;
  logic                 locked_s, fail, lost;
  logic                 pll_rst_n, ready_n, lock_lost_n, fault_n;
  logic [N_DOMAINS-1:0] dom_rst_n;

  sync2 u_lock_sync (
    .clk (clk24_ref),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    k_n       = '0;
    retries_n = retries;
    fail      = 1'b0;
    lost      = 1'b0;
    case (state)
      RESET_PLL: if (cnt == CW'(PLL_RST_CYCLES - 1)) begin
        state_n = WAIT_LOCK;
        cnt_n   = '0;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_n = STABLE;
          cnt_n   = '0;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          fail = 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          fail = 1'b1;
        end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
          state_n = RELEASE;
          cnt_n   = '0;
        end
      end
      RELEASE: begin
        k_n = k;
        if (!locked_s) begin
          lost = 1'b1;
        end else if (k == KW'(N_DOMAINS - 1)) begin
          state_n = RUN;
          cnt_n   = '0;
        end else if (cnt == CW'(RELEASE_GAP - 1)) begin
          k_n   = k + KW'(1);
          cnt_n = '0;
        end
      end
      RUN: begin
        cnt_n = '0;
        if (!locked_s) lost = 1'b1;
      end
      FAULT:   cnt_n = '0;
      default: begin
        state_n = RESET_PLL;
        cnt_n   = '0;
      end
    endcase

    if (fail) begin
      retries_n = retries + 8'd1;
      cnt_n     = '0;
      state_n   = (retries_n == 8'(MAX_RETRIES)) ? FAULT : RESET_PLL;
    end
    // Lock loss restarts the sequence without spending a retry.
    if (lost) begin
      state_n = RESET_PLL;
      cnt_n   = '0;
      k_n     = '0;
    end
    if (state_n == RUN) retries_n = '0;

    pll_rst_n   = (state_n == RESET_PLL) || (state_n == FAULT);
    ready_n     = (state_n == RUN);
    fault_n     = (state_n == FAULT);
    lock_lost_n = lost;
    for (int i = 0; i < N_DOMAINS; i++) begin
      if (state_n == RELEASE)  dom_rst_n[i] = (i > int'(k_n));
      else if (state_n == RUN) dom_rst_n[i] = 1'b0;
      else                     dom_rst_n[i] = 1'b1;
    end
  end

  always_ff @(posedge clk24_ref or posedge rst) begin
    if (rst) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      k         <= '0;
      retries   <= '0;
      pll_rst   <= 1'b1;
      dom_rst   <= '1;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      k         <= k_n;
      retries   <= retries_n;
      pll_rst   <= pll_rst_n;
      dom_rst   <= dom_rst_n;
      ready     <= ready_n;
      lock_lost <= lock_lost_n;
      fault     <= fault_n;
    end
  end

endmodule
